// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer driving one external combinational round datapath.
// Optional macro AES_RC_KEY_WAIT_EN adds key_ready and a WAIT_KEY state between accept and INIT.
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_block,
    output logic [127:0]       dp_state,
    output logic [ROUND_W-1:0] dp_round,
    output logic [1:0]         dp_mode,
    input  logic [127:0]       dp_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_block,
`ifdef AES_RC_KEY_WAIT_EN
    input  logic               key_ready,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROUND,
        ST_FINAL,
`ifdef AES_RC_KEY_WAIT_EN
        ST_WAIT_KEY,
`endif
        ST_DONE
    } state_e;

    localparam logic [ROUND_W-1:0] RND_FIRST     = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] RND_LAST_FULL = ROUND_W'(NR - 1);
    localparam logic [ROUND_W-1:0] RND_FINAL     = ROUND_W'(NR);

    localparam logic [1:0] MODE_ARK   = 2'd0;
    localparam logic [1:0] MODE_FULL  = 2'd1;
    localparam logic [1:0] MODE_FINAL = 2'd2;

    state_e               fsm_q, fsm_d;
    logic [127:0]         blk_q, blk_d;
    logic [ROUND_W-1:0]   rnd_q, rnd_d;

    assign dp_state  = blk_q;
    assign out_block = blk_q;
    assign out_valid = (fsm_q == ST_DONE);

    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        rnd_d    = rnd_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        dp_round = '0;
        dp_mode  = MODE_ARK;

        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
`ifdef AES_RC_KEY_WAIT_EN
            ST_WAIT_KEY: begin
                busy = 1'b1;
                if (key_ready) begin
                    fsm_d = ST_INIT;
                end
            end
`endif
            ST_INIT: begin
                busy  = 1'b1;
                blk_d = dp_result;
                rnd_d = RND_FIRST;
                fsm_d = ST_ROUND;
            end
            ST_ROUND: begin
                busy     = 1'b1;
                dp_round = rnd_q;
                dp_mode  = MODE_FULL;
                blk_d    = dp_result;
                rnd_d    = rnd_q + ROUND_W'(1);
                if (rnd_q == RND_LAST_FULL) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                busy     = 1'b1;
                dp_round = RND_FINAL;
                dp_mode  = MODE_FINAL;
                blk_d    = dp_result;
                fsm_d    = ST_DONE;
            end
            ST_DONE: begin
                // Ready to the source only when the sink drains this cycle.
                in_ready = out_ready;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        if (in_valid && in_ready) begin
            blk_d = in_block;
            rnd_d = '0;
`ifdef AES_RC_KEY_WAIT_EN
            fsm_d = ST_WAIT_KEY;
`else
            fsm_d = ST_INIT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
            blk_q <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            blk_q <= blk_d;
            rnd_q <= rnd_d;
        end
    end

    // A backpressured result must stay put until the sink takes it.
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_block)));

    a_round_max: assert property (@(posedge clk) disable iff (rst)
        dp_round <= RND_FINAL);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: real AES-128 round datapath and key bank around the controller,
// FIPS-197 vectors plus random blocks checked against a whole-cipher reference function.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;
`ifdef AES_RC_KEY_WAIT_EN
    localparam int KW = 1;
`else
    localparam int KW = 0;
`endif
    localparam int LAT = NR + 1 + KW;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [127:0]  in_block  = '0;
    logic          in_ready, out_valid, busy;
    logic [127:0]  dp_state, dp_result, out_block;
    logic [RW-1:0] dp_round;
    logic [1:0]    dp_mode;
`ifdef AES_RC_KEY_WAIT_EN
    logic          key_ready = 1'b1;
`endif

    logic [7:0]    sbox    [256];
    logic [127:0]  rk_bank [16];
    logic [127:0]  rk_sel;

    int checks = 0;
    int errors = 0;

    aes_round_ctrl #(.NR(NR), .ROUND_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .dp_state  (dp_state),
        .dp_round  (dp_round),
        .dp_mode   (dp_mode),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
`ifdef AES_RC_KEY_WAIT_EN
        .key_ready (key_ready),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Whole-cipher reference: no notion of cycles or controller state.
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(key, 0);
        for (int r = 1; r < NR; r++) s = mix_cols(shift_rows(sub_bytes(s))) ^ round_key(key, r);
        return shift_rows(sub_bytes(s)) ^ round_key(key, NR);
    endfunction

    // Combinational round datapath and key bank seen by the controller.
    always_comb begin
        rk_sel = rk_bank[dp_round];
        case (dp_mode)
            2'd0:    dp_result = dp_state ^ rk_sel;
            2'd1:    dp_result = mix_cols(shift_rows(sub_bytes(dp_state))) ^ rk_sel;
            2'd2:    dp_result = shift_rows(sub_bytes(dp_state)) ^ rk_sel;
            default: dp_result = '0;
        endcase
    end

    // ---------------- bench utilities ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] key);
        for (int r = 0; r <= NR; r++) rk_bank[r] = round_key(key, r);
    endtask

    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One block: accept, per-cycle round/mode trace, latency, result, optional stall in DONE.
    task automatic run_block(input string nm, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int stall);
        int  edges, k;
        bit  seen;
        load_key(key);
        in_block  = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chki({nm, " in_ready idle"}, int'(in_ready), 1);
        tick;
        in_block = ~pt;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < LAT + 20) begin
            k = edges - KW;
            chki({nm, " busy"}, int'(busy), 1);
            if (k >= 0 && k <= NR) begin
                chki($sformatf("%s dp_round k%0d", nm, k), int'(dp_round), k);
                chki($sformatf("%s dp_mode k%0d", nm, k), int'(dp_mode), (k == 0) ? 0 : ((k == NR) ? 2 : 1));
            end
            tick;
            edges++;
            seen = out_valid;
        end
        chki({nm, " latency"}, edges, LAT);
        for (int i = 0; i <= stall; i++) begin
            chkv({nm, " ct"}, out_block, ct);
            chki({nm, " out_valid"}, int'(out_valid), 1);
            chki({nm, " in_ready stalled"}, int'(in_ready), 0);
            chki({nm, " busy done"}, int'(busy), 0);
            chki({nm, " dp_mode done"}, int'(dp_mode), 0);
            if (i < stall) tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chki({nm, " in_ready release"}, int'(in_ready), 1);
        tick;
        out_ready = 1'b0;
        chki({nm, " single transfer"}, int'(out_valid), 0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [127:0] ka, pa, pb, cb;
        logic [127:0] expq [2];
        int nacc, nout, hits;
        int acc_cyc [2];
        int out_cyc [2];
        bit acc, xfer;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int r = 0; r < 16; r++) rk_bank[r] = '0;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 0};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 20};
        for (int i = 2; i < 6; i++) begin
            vecs[i].key   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].pt    = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct    = aes_ref(vecs[i].key, vecs[i].pt);
            vecs[i].stall = int'($urandom_range(0, 4));
        end

        // Reset values
        rst = 1'b1;
        tick;
        tick;
        chki("rst out_valid", int'(out_valid), 0);
        chki("rst busy", int'(busy), 0);
        chki("rst dp_mode", int'(dp_mode), 0);
        chki("rst dp_round", int'(dp_round), 0);
        chkv("rst dp_state", dp_state, '0);
        rst = 1'b0;
        tick;
        chki("idle in_ready", int'(in_ready), 1);

        for (int i = 0; i < 6; i++)
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].stall);

        // Back-to-back: in_valid held, sink always ready
        ka = vecs[0].key;
        pa = vecs[0].pt;
        pb = {$urandom, $urandom, $urandom, $urandom};
        cb = aes_ref(ka, pb);
        expq[0] = vecs[0].ct;
        expq[1] = cb;
        load_key(ka);
        in_block  = pa;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nacc = 0;
        nout = 0;
        for (int cyc = 0; cyc < 80 && nout < 2; cyc++) begin
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                chkv($sformatf("b2b ct%0d", nout), out_block, expq[nout]);
                out_cyc[nout] = cyc;
                nout++;
            end
            if (acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            tick;
            if (acc) begin
                if (nacc == 1) in_block = pb;
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chki("b2b transfers", nout, 2);
        chki("b2b accepts", nacc, 2);
        if (nacc == 2 && nout == 2) begin
            chki("b2b accept spacing", acc_cyc[1] - acc_cyc[0], NR + 2 + KW);
            chki("b2b accept on drain", acc_cyc[1], out_cyc[0]);
        end
        tick;

        // Reset while in round 5 drops the block
        load_key(vecs[2].key);
        in_block = vecs[2].pt;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 5 + KW; i++) tick;
        chki("mid dp_round", int'(dp_round), 5);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chki("mid rst busy", int'(busy), 0);
        chki("mid rst out_valid", int'(out_valid), 0);
        chki("mid rst in_ready", int'(in_ready), 1);
        chki("mid rst dp_round", int'(dp_round), 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) hits++;
            tick;
        end
        chki("mid rst no out_valid", hits, 0);
        run_block("post-rst", vecs[0].key, vecs[0].pt, vecs[0].ct, 0);

`ifdef AES_RC_KEY_WAIT_EN
        // key_ready withheld for 7 cycles after accept
        load_key(vecs[1].key);
        key_ready = 1'b0;
        in_block  = vecs[1].pt;
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chki("kw dp_round", int'(dp_round), 0);
            chki("kw busy", int'(busy), 1);
            chki("kw out_valid", int'(out_valid), 0);
            tick;
        end
        key_ready = 1'b1;
        tick;
        key_ready = 1'b0;
        hits = 0;
        while (!out_valid && hits < 40) begin
            tick;
            hits++;
        end
        chki("kw latency", hits, NR + 1);
        chkv("kw ct", out_block, vecs[1].ct);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        key_ready = 1'b1;
        chki("kw drained", int'(out_valid), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
